// File: rtl/usb_bit_unstuffer_fifo_if.sv
// Bit-stream handshake between the NRZI decoder, the unstuffer and the
// packet deserialiser. The input side has no backpressure. The output side
// uses valid/ready.
interface usb_bit_unstuffer_fifo_if;
  logic in_bit;
  logic in_valid;
  logic out_bit;
  logic out_valid;
  logic out_ready;

  modport master (output in_bit, output in_valid, output out_ready,
                  input  out_bit, input  out_valid);
  modport slave  (input  in_bit, input  in_valid, input  out_ready,
                  output out_bit, output out_valid);
endinterface

// File: rtl/usb_bit_unstuffer_fifo.sv
// USB receive bit unstuffer with an output FIFO.
// After RUN_LEN consecutive data 1s, the next valid bit is a stuffed bit.
// That stuffed bit is removed from the stream. Surviving bits are queued in
// a DEPTH-entry FIFO so the deserialiser can stall briefly.
// Optional feature macro: USB_UNSTUFF_ERR_EN. When it is defined, a stuffed
// position that carries a 1 pulses stuff_err.
module usb_bit_unstuffer_fifo #(
  parameter  int RUN_LEN = 6,
  parameter  int DEPTH   = 4,
  localparam int CNT_W   = $clog2(RUN_LEN + 1),
  localparam int LVL_W   = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   RST,
  input  logic                   clear,
  usb_bit_unstuffer_fifo_if.slave bus,
  output logic [CNT_W-1:0]       run_count,
  output logic                   stuff_err,
  output logic                   overflow,
  output logic [LVL_W-1:0]       fifo_level
);
  localparam int PTR_W = $clog2(DEPTH);

  logic             drop_q, drop_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             stuff_err_q, stuff_err_d;
  logic             overflow_q, overflow_d;

  logic             drop_eff;
  logic [CNT_W-1:0] run_eff;
  logic             is_data, is_stuff, full, push, pop;

  assign bus.out_valid = (level_q != '0);
  assign bus.out_bit   = bus.out_valid & mem_q[rptr_q];
  assign run_count     = run_q;
  assign fifo_level    = level_q;
  assign stuff_err     = stuff_err_q;
  assign overflow      = overflow_q;

  // Run tracking and FIFO next-state.
  // A clear wipes the run state before the current bit is processed.
  always_comb begin
    drop_eff = clear ? 1'b0 : drop_q;
    run_eff  = clear ? '0   : run_q;
    is_data  = bus.in_valid & ~drop_eff;
    is_stuff = bus.in_valid &  drop_eff;
    full     = (level_q == LVL_W'(DEPTH));
    pop      = bus.out_valid & bus.out_ready;
    // A full FIFO can still accept a bit when the head leaves on the same edge.
    push     = is_data & (~full | pop);

    drop_d = drop_eff;
    run_d  = run_eff;
    if (is_data) begin
      if (bus.in_bit) begin
        run_d = run_eff + CNT_W'(1);
        if (run_eff == CNT_W'(RUN_LEN - 1)) drop_d = 1'b1;
      end else begin
        run_d = '0;
      end
    end else if (is_stuff) begin
      drop_d = 1'b0;
      run_d  = '0;
    end

`ifdef USB_UNSTUFF_ERR_EN
    stuff_err_d = is_stuff & bus.in_bit;
`else
    stuff_err_d = 1'b0;
`endif
    // A discarded bit still advances the run state above. Only the data is lost.
    overflow_d = is_data & full & ~pop;

    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      mem_d[wptr_q] = bus.in_bit;
      wptr_d        = wptr_q + PTR_W'(1);
    end
    if (pop) rptr_d = rptr_q + PTR_W'(1);

    level_d = level_q;
    if (push && !pop)      level_d = level_q + LVL_W'(1);
    else if (pop && !push) level_d = level_q - LVL_W'(1);
  end

  // State registers. Reset discards queued bits and any partial run.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      drop_q      <= 1'b0;
      run_q       <= '0;
      mem_q       <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      stuff_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      drop_q      <= drop_d;
      run_q       <= run_d;
      mem_q       <= mem_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      stuff_err_q <= stuff_err_d;
      overflow_q  <= overflow_d;
    end
  end
endmodule

// File: tb/tb_usb_bit_unstuffer_fifo.sv
// Directed bench for usb_bit_unstuffer_fifo with RUN_LEN=6 and DEPTH=4.
module tb_usb_bit_unstuffer_fifo;
  localparam int CNT_W = 3;
  localparam int LVL_W = 3;
`ifdef USB_UNSTUFF_ERR_EN
  localparam int EXP_ERR = 1;
`else
  localparam int EXP_ERR = 0;
`endif

  logic clk = 1'b0;
  logic RST = 1'b1;
  logic clear = 1'b0;
  logic [CNT_W-1:0] run_count;
  logic stuff_err, overflow;
  logic [LVL_W-1:0] fifo_level;
  int n_cmp = 0;
  int n_bad = 0;
  logic got[$];

  usb_bit_unstuffer_fifo_if bus();

  usb_bit_unstuffer_fifo #(.RUN_LEN(6), .DEPTH(4)) dut (
    .clk(clk), .RST(RST), .clear(clear), .bus(bus.slave),
    .run_count(run_count), .stuff_err(stuff_err), .overflow(overflow),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Drive one input cycle. Record the bit that pops on this edge, then settle after the edge.
  task automatic step(input logic b, input logic v, input logic c);
    bus.in_bit   = b;
    bus.in_valid = v;
    clear        = c;
    #1;
    if (bus.out_valid && bus.out_ready) got.push_back(bus.out_bit);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    clear        = 1'b0;
  endtask

  // Compare the popped bits with a '0'/'1' string, oldest bit first.
  task automatic check_out(input string tag, input string exp);
    chk({tag, "_cnt"}, got.size(), exp.len());
    for (int i = 0; i < exp.len() && i < got.size(); i++)
      chk($sformatf("%s_bit%0d", tag, i), int'(got[i]), (exp[i] == "1") ? 1 : 0);
    got.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, bus.out_valid, 0);
    chk({tag, "_bit"},   bus.out_bit,   0);
    chk({tag, "_run"},   run_count,     0);
    chk({tag, "_err"},   stuff_err,     0);
    chk({tag, "_ovf"},   overflow,      0);
    chk({tag, "_lvl"},   fifo_level,    0);
  endtask

  initial begin
    static logic [7:0] t2_bits = 8'b1011_1111;  // bit 0 is sent first: 1,1,1,1,1,1,0,1
    static int t2_run[8] = '{1, 2, 3, 4, 5, 6, 0, 1};
    static logic [4:0] t4_bits = 5'b01010;     // sent as 0,1,0,1,0
    static logic [5:0] t6_bits = 6'b010110;    // sent as 0,1,1,0,1,0

    bus.in_bit = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst_init");
    @(negedge clk) RST = 1'b0;
    @(posedge clk); #1;

    // Reset mid-stream: queue three bits, then assert RST between edges.
    step(1, 1, 0); step(0, 1, 0); step(1, 1, 0);
    chk("pre_rst_lvl", fifo_level, 3);
    chk("pre_rst_run", run_count, 1);
    #2 RST = 1'b1;
    #1 chk_zero("rst_async");
    @(negedge clk) RST = 1'b0;
    @(posedge clk); #1;
    repeat (3) step(0, 0, 0);
    chk_zero("idle");

    // Basic unstuffing: the 0 after six 1s is removed.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(t2_bits[i], 1, 0);
      chk($sformatf("t2_run%0d", i), run_count, t2_run[i]);
      chk($sformatf("t2_err%0d", i), stuff_err, 0);
    end
    step(0, 0, 0);
    check_out("t2_out", "1111111");

    // Stuff violation: seven 1s. The first bit carries clear to start from a clean run.
    for (int i = 0; i < 7; i++) begin
      step(1, 1, (i == 0));
      chk($sformatf("t3_run%0d", i), run_count, (i < 6) ? i + 1 : 0);
      chk($sformatf("t3_err%0d", i), stuff_err, (i == 6) ? EXP_ERR : 0);
    end
    step(0, 0, 0);
    chk("t3_err_after", stuff_err, 0);
    check_out("t3_out", "111111");

    // Backpressure and overflow.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(t4_bits[i], 1, 0);
      chk($sformatf("t4_lvl%0d", i), fifo_level, (i < 4) ? i + 1 : 4);
      chk($sformatf("t4_ovf%0d", i), overflow, (i == 4) ? 1 : 0);
    end
    step(0, 0, 0);
    chk("t4_ovf_after", overflow, 0);
    chk("t4_lvl_hold", fifo_level, 4);
    bus.out_ready = 1'b1;
    repeat (4) step(0, 0, 0);
    check_out("t4_out", "0101");
    chk("t4_lvl_end", fifo_level, 0);
    chk("t4_valid_end", bus.out_valid, 0);
    chk("t4_bit_end", bus.out_bit, 0);

    // clear on the sixth 1 restarts the run, so the next 0 is data.
    for (int i = 0; i < 5; i++) step(1, 1, 0);
    chk("t5_run5", run_count, 5);
    step(1, 1, 1);
    chk("t5_run_clr", run_count, 1);
    step(0, 1, 0);
    chk("t5_run_0", run_count, 0);
    step(0, 0, 0);
    check_out("t5_out", "1111110");

    // Full FIFO with a push and a pop on every edge.
    bus.out_ready = 1'b0;
    step(1, 1, 0); step(0, 1, 0); step(0, 1, 0); step(1, 1, 0);
    chk("t6_lvl_full", fifo_level, 4);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(t6_bits[i], 1, 0);
      chk($sformatf("t6_lvl%0d", i), fifo_level, 4);
      chk($sformatf("t6_ovf%0d", i), overflow, 0);
    end
    repeat (4) step(0, 0, 0);
    check_out("t6_out", "1001011010");
    chk("t6_lvl_end", fifo_level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
